// File: rtl/unidad_aritmetica.sv
// Sequential add/sub/mul/div unit with start/busy/done handshake.
// Optional feature: define ALU_SIGNED_SUB_EN for two's-complement subtraction.
module unidad_aritmetica #(
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   binA,
  input  logic [WIDTH-1:0]   binB,
  input  logic [1:0]         modo,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] resultado,
  output logic [WIDTH-1:0]   residuo,
  output logic               negativo,
  output logic               div_cero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state;
  logic [WIDTH-1:0]    a_reg, b_reg;
  logic [1:0]          modo_reg;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  acc, mcand;
  logic [WIDTH-1:0]    rem, quo;

  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  mul_next;
  logic [WIDTH:0]      rem_sh, rem_sub;
  logic                ge;
  logic [WIDTH-1:0]    rem_next, quo_next;
  logic [2*WIDTH-1:0]  sub_res;
  logic                sub_neg;

  always_comb begin
    sum      = {1'b0, a_reg} + {1'b0, b_reg};
    mul_next = acc + (b_reg[cnt] ? mcand : '0);
    // restoring step: sign of the trial subtraction decides the quotient bit
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, b_reg};
    ge       = ~rem_sub[WIDTH];
    rem_next = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

`ifdef ALU_SIGNED_SUB_EN
  logic [WIDTH:0] diff;
  always_comb begin
    diff    = {1'b0, a_reg} - {1'b0, b_reg};
    sub_res = {{(WIDTH-1){diff[WIDTH]}}, diff};
    sub_neg = diff[WIDTH];
  end
`else
  always_comb begin
    sub_neg = (a_reg < b_reg);
    sub_res = {{WIDTH{1'b0}}, (sub_neg ? (b_reg - a_reg) : (a_reg - b_reg))};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      modo_reg  <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      rem       <= '0;
      quo       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
      residuo   <= '0;
      negativo  <= 1'b0;
      div_cero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= binA;
            b_reg     <= binB;
            modo_reg  <= modo;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, binA};
            rem       <= '0;
            quo       <= binA;
            resultado <= '0;
            residuo   <= '0;
            negativo  <= 1'b0;
            div_cero  <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          case (modo_reg)
            2'b00: begin
              resultado <= {{(WIDTH-1){1'b0}}, sum};
              busy <= 1'b0; done <= 1'b1; state <= FIN;
            end
            2'b01: begin
              resultado <= sub_res;
              negativo  <= sub_neg;
              busy <= 1'b0; done <= 1'b1; state <= FIN;
            end
            2'b10: begin
              acc   <= mul_next;
              mcand <= mcand << 1;
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_LAST) begin
                resultado <= mul_next;
                busy <= 1'b0; done <= 1'b1; state <= FIN;
              end
            end
            default: begin
              if (b_reg == '0) begin
                resultado <= '1;
                residuo   <= a_reg;
                div_cero  <= 1'b1;
                busy <= 1'b0; done <= 1'b1; state <= FIN;
              end else begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                  resultado <= {{WIDTH{1'b0}}, quo_next};
                  residuo   <= rem_next;
                  busy <= 1'b0; done <= 1'b1; state <= FIN;
                end
              end
            end
          endcase
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
